// File: rtl/div_pkg.sv
// Shared definitions for the divide sequencer: FSM encoding, defaults and
// the signed-overflow operand check.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam int unsigned SETTLE_CYCLES_DEFAULT = 4;
   localparam logic [31:0] INT_MIN               = 32'h8000_0000;

   // INT_MIN / -1 is the only signed quotient that does not fit in 32 bits.
   function automatic logic is_signed_ovf(input logic [31:0] rn,
                                          input logic [31:0] rm,
                                          input logic        mode);
      return (mode == 1'b0) && (rn == INT_MIN) && (rm == 32'hFFFF_FFFF);
   endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request / divider / response bundle between the divide sequencer (slave)
// and its parent (master), which also owns the combinational divider.
interface div_sequencer_if;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_rn;
   logic [31:0] req_rm;
   logic        req_mode;
   logic [3:0]  req_rd;

   logic [31:0] div_rn;
   logic [31:0] div_rm;
   logic        div_mode;
   logic [31:0] div_y;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_rd;
   logic        rsp_dz;
   logic        rsp_ovf;

   logic        busy;

   modport slave (
      input  req_valid, req_rn, req_rm, req_mode, req_rd, div_y, rsp_ready,
      output req_ready, div_rn, div_rm, div_mode,
             rsp_valid, rsp_result, rsp_rd, rsp_dz, rsp_ovf, busy
   );

   modport master (
      output req_valid, req_rn, req_rm, req_mode, req_rd, div_y, rsp_ready,
      input  req_ready, div_rn, div_rm, div_mode,
             rsp_valid, rsp_result, rsp_rd, rsp_dz, rsp_ovf, busy
   );

endinterface

// File: rtl/div_sequencer.sv
// Divide sequencer: latches a request, holds the operands on the external
// combinational divider for SETTLE_CYCLES cycles, then captures the quotient.
// Divide-by-zero skips the wait; INT_MIN / -1 (signed) is forced to INT_MIN.
module div_sequencer
   import div_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
   input  logic           clk,
   input  logic           reset_n,
   div_sequencer_if.slave bus
);

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rn_q, rn_d;
   logic [31:0] rm_q, rm_d;
   logic        mode_q, mode_d;
   logic [3:0]  rd_q, rd_d;
   logic [31:0] result_q, result_d;
   logic        dz_q, dz_d;
   logic        ovf_q, ovf_d;
   logic        req_ready_c;
   logic        hs_c;
   logic        ovf_c;

   assign ovf_c = is_signed_ovf(rn_q, rm_q, mode_q);

   // Next-state, counter and datapath load decisions.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rn_d        = rn_q;
      rm_d        = rm_q;
      mode_d      = mode_q;
      rd_d        = rd_q;
      result_d    = result_q;
      dz_d        = dz_q;
      ovf_d       = ovf_q;
      req_ready_c = 1'b0;
      hs_c        = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready_c = 1'b1;
         end
         SETTLE: begin
            if (cnt_q == 4'd0) begin
               state_d  = DONE;
               result_d = ovf_c ? INT_MIN : bus.div_y;
               ovf_d    = ovf_c;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            // Retiring and accepting share one edge so there is no bubble.
            req_ready_c = bus.rsp_ready;
            if (bus.rsp_ready && !bus.req_valid) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      hs_c = bus.req_valid && req_ready_c;
      if (hs_c) begin
         rn_d     = bus.req_rn;
         rm_d     = bus.req_rm;
         mode_d   = bus.req_mode;
         rd_d     = bus.req_rd;
         result_d = 32'd0;
         ovf_d    = 1'b0;
         dz_d     = (bus.req_rm == 32'd0);
         if (bus.req_rm == 32'd0) begin
            state_d = DONE;
         end else begin
            state_d = SETTLE;
            cnt_d   = CNT_LOAD;
         end
      end
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         rn_q     <= 32'd0;
         rm_q     <= 32'd0;
         mode_q   <= 1'b0;
         rd_q     <= 4'd0;
         result_q <= 32'd0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rn_q     <= rn_d;
         rm_q     <= rm_d;
         mode_q   <= mode_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.div_rn     = rn_q;
   assign bus.div_rm     = rm_q;
   assign bus.div_mode   = mode_q;
   assign bus.rsp_valid  = (state_q == DONE);
   assign bus.rsp_result = result_q;
   assign bus.rsp_rd     = rd_q;
   assign bus.rsp_dz     = dz_q;
   assign bus.rsp_ovf    = ovf_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed cases plus a randomized run, checked
// against an arithmetic reference model. The divider stub returns garbage
// until its operands have been stable long enough, so early capture shows.
module tb_div_sequencer;
   import div_pkg::*;

   localparam int SC = 4;

   logic clk;
   logic reset_n;
   int   n_cmp = 0;
   int   n_err = 0;

   div_sequencer_if bus();

   div_sequencer #(.SETTLE_CYCLES(SC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- divider stub (the parent's divider unit) -------------
   logic [31:0]        prev_rn = '0;
   logic [31:0]        prev_rm = '0;
   logic               prev_mode = 1'b0;
   int                 age = 100;
   logic signed [63:0] sa, sb, sq;
   logic [31:0]        ma, mb, q_true;

   // Operand age: edges since the divider inputs last changed.
   always @(posedge clk) begin
      if (bus.div_rn !== prev_rn || bus.div_rm !== prev_rm || bus.div_mode !== prev_mode) begin
         age       <= 0;
         prev_rn   <= bus.div_rn;
         prev_rm   <= bus.div_rm;
         prev_mode <= bus.div_mode;
      end else if (age < 100) begin
         age <= age + 1;
      end
   end

   // Quotient, valid only once settled.
   always_comb begin
      sa = {{32{bus.div_rn[31]}}, bus.div_rn};
      sb = {{32{bus.div_rm[31]}}, bus.div_rm};
      sq = '0;
      ma = bus.div_rn[31] ? -bus.div_rn : bus.div_rn;
      mb = bus.div_rm[31] ? -bus.div_rm : bus.div_rm;
      if (bus.div_rm == 32'd0)
         q_true = 32'hFFFF_FFFF;
      else if (!bus.div_mode && bus.div_rn == INT_MIN && bus.div_rm == 32'hFFFF_FFFF)
         q_true = 32'h0BAD_0BAD;
      else if (!bus.div_mode) begin
         sq     = sa / sb;
         q_true = sq[31:0];
      end else
         q_true = ma / mb;
      bus.div_y = (age >= SC - 2) ? q_true : 32'hDEAD_BEEF;
   end

   // ---------------- reference model: {dz, ovf, result} -------------------
   function automatic logic [33:0] ref_div(input logic [31:0] rn, input logic [31:0] rm,
                                           input logic mode);
      logic [31:0] mn, mm, q;
      if (rm == 32'd0) return {1'b1, 1'b0, 32'd0};
      if (!mode && rn == 32'h8000_0000 && rm == 32'hFFFF_FFFF)
         return {1'b0, 1'b1, 32'h8000_0000};
      mn = rn[31] ? (~rn + 32'd1) : rn;
      mm = rm[31] ? (~rm + 32'd1) : rm;
      q  = mn / mm;
      if (!mode && (rn[31] ^ rm[31])) q = ~q + 32'd1;
      return {1'b0, 1'b0, q};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"},    32'(bus.busy),      32'd0);
      chk({tag, "_rdy"},     32'(bus.req_ready), 32'd1);
      chk({tag, "_valid"},   32'(bus.rsp_valid), 32'd0);
      chk({tag, "_divrn"},   bus.div_rn,         32'd0);
      chk({tag, "_divrm"},   bus.div_rm,         32'd0);
      chk({tag, "_divmode"}, 32'(bus.div_mode),  32'd0);
      chk({tag, "_result"},  bus.rsp_result,     32'd0);
      chk({tag, "_rd"},      32'(bus.rsp_rd),    32'd0);
      chk({tag, "_dz"},      32'(bus.rsp_dz),    32'd0);
      chk({tag, "_ovf"},     32'(bus.rsp_ovf),   32'd0);
   endtask

   task automatic drive_req(input logic [31:0] rn, input logic [31:0] rm,
                            input logic mode, input logic [3:0] rd);
      bus.req_valid = 1'b1;
      bus.req_rn    = rn;
      bus.req_rm    = rm;
      bus.req_mode  = mode;
      bus.req_rd    = rd;
   endtask

   // Request fields become noise once the handshake edge has passed.
   task automatic scramble_req();
      bus.req_valid = 1'b0;
      bus.req_rn    = $urandom;
      bus.req_rm    = $urandom;
      bus.req_mode  = 1'($urandom);
      bus.req_rd    = 4'($urandom);
   endtask

   // Handshake from IDLE.
   task automatic launch(input logic [31:0] rn, input logic [31:0] rm,
                         input logic mode, input logic [3:0] rd);
      @(negedge clk);
      drive_req(rn, rm, mode, rd);
      #1;
      chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      scramble_req();
   endtask

   // Called just after a handshake edge; ends at the negedge showing the result.
   task automatic expect_rsp(input logic [31:0] rn, input logic [31:0] rm,
                             input logic mode, input logic [3:0] rd, input string tag);
      logic [33:0] e;
      int lat;
      e   = ref_div(rn, rm, mode);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.rsp_valid) break;
         chk({tag, "_busy_wait"}, 32'(bus.busy), 32'd1);
      end
      chk({tag, "_latency"}, 32'(lat), (rm == 32'd0) ? 32'd1 : 32'(SC));
      chk({tag, "_result"},  bus.rsp_result,       e[31:0]);
      chk({tag, "_ovf"},     32'(bus.rsp_ovf),     32'(e[32]));
      chk({tag, "_dz"},      32'(bus.rsp_dz),      32'(e[33]));
      chk({tag, "_rd"},      32'(bus.rsp_rd),      32'(rd));
      chk({tag, "_divrn"},   bus.div_rn,           rn);
      chk({tag, "_divrm"},   bus.div_rm,           rm);
      chk({tag, "_divmode"}, 32'(bus.div_mode),    32'(mode));
      chk({tag, "_rdy_done"}, 32'(bus.req_ready),  32'(bus.rsp_ready));
   endtask

   task automatic retire(input string tag);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_ret_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_ret_busy"},  32'(bus.busy),      32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rn, rm;
      logic        mode;
      logic [3:0]  rd;
      logic [33:0] held;
      bit          have_rsp;
      int          sel;

      reset_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_rn = '0; bus.req_rm = '0;
      bus.req_mode = 1'b0; bus.req_rd = '0; bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      reset_n = 1'b1;

      // Signed 100 / -7.
      launch(32'd100, 32'hFFFF_FFF9, 1'b0, 4'd3);
      expect_rsp(32'd100, 32'hFFFF_FFF9, 1'b0, 4'd3, "s100_m7");
      chk("s100_m7_const", bus.rsp_result, 32'hFFFF_FFF2);
      retire("s100_m7");

      // Divide by zero, both modes.
      launch(32'd55, 32'd0, 1'b0, 4'd4);
      expect_rsp(32'd55, 32'd0, 1'b0, 4'd4, "dz_signed");
      retire("dz_signed");
      launch(32'd55, 32'd0, 1'b1, 4'd5);
      expect_rsp(32'd55, 32'd0, 1'b1, 4'd5, "dz_mag");
      retire("dz_mag");

      // INT_MIN / -1 signed overflow.
      launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'd6);
      expect_rsp(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'd6, "ovf");
      retire("ovf");

      // Stall in DONE with a queued request, then back-to-back accept.
      launch(32'd123456, 32'd789, 1'b0, 4'd7);
      expect_rsp(32'd123456, 32'd789, 1'b0, 4'd7, "stall");
      held = ref_div(32'd123456, 32'd789, 1'b0);
      drive_req(32'hFFFF_FFEC, 32'd3, 1'b1, 4'd9);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_valid",  32'(bus.rsp_valid), 32'd1);
         chk("stall_result", bus.rsp_result,     held[31:0]);
         chk("stall_rd",     32'(bus.rsp_rd),    32'd7);
         chk("stall_flags",  {30'd0, bus.rsp_dz, bus.rsp_ovf}, {30'd0, held[33], held[32]});
         chk("stall_rdy",    32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      scramble_req();
      expect_rsp(32'hFFFF_FFEC, 32'd3, 1'b1, 4'd9, "b2b");
      chk("b2b_const", bus.rsp_result, 32'd6);
      retire("b2b");

      // Reset during SETTLE drops the operation.
      launch(32'd1000, 32'd10, 1'b0, 4'd2);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk_reset("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("post_reset_valid", 32'(bus.rsp_valid), 32'd0);
      end
      launch(32'd1000, 32'd10, 1'b0, 4'd2);
      expect_rsp(32'd1000, 32'd10, 1'b0, 4'd2, "after_reset");
      retire("after_reset");

      // req_rm changed during SETTLE.
      launch(32'd77, 32'd5, 1'b0, 4'd1);
      bus.req_rm = 32'd0;
      expect_rsp(32'd77, 32'd5, 1'b0, 4'd1, "rm_change");
      retire("rm_change");

      // Randomized mix, sometimes retiring and accepting on the same edge.
      have_rsp = 1'b0;
      for (int i = 0; i < 40; i++) begin
         rn   = $urandom;
         mode = 1'($urandom_range(0, 1));
         rd   = 4'($urandom);
         sel  = $urandom_range(0, 9);
         if (sel == 0)      rm = 32'd0;
         else if (sel == 1) begin rn = 32'h8000_0000; rm = 32'hFFFF_FFFF; mode = 1'b0; end
         else if (sel <= 4) rm = 32'($urandom_range(1, 20));
         else               rm = $urandom;
         if (rm == 32'd0 && sel != 0) rm = 32'd1;
         if (have_rsp && $urandom_range(0, 1) == 1) begin
            drive_req(rn, rm, mode, rd);
            bus.rsp_ready = 1'b1;
            #1;
            chk("rand_b2b_rdy", 32'(bus.req_ready), 32'd1);
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b0;
            scramble_req();
         end else begin
            if (have_rsp) retire("rand");
            launch(rn, rm, mode, rd);
         end
         expect_rsp(rn, rm, mode, rd, "rand");
         have_rsp = 1'b1;
      end
      retire("rand_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the number of clock cycles the combinational divider is allowed to settle (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  divide request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_rn  input  32  dividend.
REQ-007 req_rm  input  32  divisor.
REQ-008 req_mode  input  1  0 = signed, 1 = magnitude (unsigned) divide; passed unchanged to the divider.
REQ-009 req_rd  input  4  destination register tag.
REQ-010 div_rn, div_rm  output  32 each  held operands driven to the divider unit.
REQ-011 div_mode  output  1  held mode driven to the divider unit.
REQ-012 div_y  input  32  quotient returned by the divider unit.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  writeback stage accepts the result.
REQ-015 rsp_result  output  32  registered quotient.
REQ-016 rsp_rd  output  4  tag of the result.
REQ-017 rsp_dz  output  1  divide-by-zero flag for this result.
REQ-018 rsp_ovf  output  1  signed-overflow flag for this result.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, SETTLE and DONE.
REQ-021 req_ready SHALL be 1 in IDLE, equal rsp_ready in DONE, and be 0 in SETTLE.
REQ-022 On a request handshake (req_valid and req_ready), the block SHALL register rn, rm, mode and rd, and div_rn, div_rm and div_mode SHALL hold these values until the next handshake.
REQ-023 A handshake with req_rm != 0 SHALL move the FSM to SETTLE and load the down-counter with SETTLE_CYCLES-1.
REQ-024 In SETTLE, the counter SHALL decrement each cycle, and when it is 0 the block SHALL capture div_y into rsp_result and move to DONE, so rsp_valid rises exactly SETTLE_CYCLES cycles after the handshake edge.
REQ-025 A handshake with req_rm == 0 (either mode) SHALL bypass SETTLE and move directly to DONE with rsp_result = 0 and rsp_dz = 1, so rsp_valid rises 1 cycle after the handshake.
REQ-026 In signed mode with rn = 0x80000000 and rm = 0xFFFFFFFF, the block SHALL take the SETTLE path and SHALL force rsp_result = 0x80000000 and rsp_ovf = 1, regardless of div_y.
REQ-027 rsp_dz and rsp_ovf SHALL be 0 for all other results and SHALL never both be 1.
REQ-028 rsp_valid SHALL be 1 only in DONE.
REQ-029 While rsp_valid is 1 and rsp_ready is 0, rsp_result, rsp_rd, rsp_dz and rsp_ovf SHALL be held stable.
REQ-030 In DONE, rsp_ready = 1 with req_valid = 0 SHALL return the FSM to IDLE.
REQ-031 In DONE, rsp_ready = 1 with req_valid = 1 SHALL retire the current result and accept the new request on the same edge (back-to-back, no bubble).
REQ-032 req_* input changes outside a handshake SHALL have no effect.

Reset
REQ-033 While reset_n = 0, the block SHALL be in IDLE with the counter, div_rn, div_rm, div_mode, rsp_result, rsp_rd, rsp_dz and rsp_ovf all 0; rsp_valid and busy SHALL be 0 and req_ready SHALL be 1.
REQ-034 Reset asserted mid-SETTLE or mid-DONE SHALL discard the in-flight operation with no response emitted.

Structure
REQ-035 A shared package div_pkg SHALL hold the state encoding (IDLE, SETTLE, DONE), SETTLE_CYCLES_DEFAULT = 4, and INT_MIN = 0x80000000.
REQ-036 The block SHALL contain no sub-module; the parent SHALL instantiate the divider unit alongside it and connect it through div_rn, div_rm, div_mode and div_y.

Verification
REQ-037 Test: signed, rn = 100, rm = -7, SETTLE_CYCLES = 4 -> rsp_valid rises 4 cycles after the handshake, rsp_result = 0xFFFFFFF2 (-14), rsp_dz = 0, rsp_ovf = 0.
REQ-038 Test: rm = 0, rn = 55, either mode -> rsp_valid after 1 cycle, rsp_result = 0, rsp_dz = 1.
REQ-039 Test: signed, rn = 0x80000000, rm = 0xFFFFFFFF -> rsp_result = 0x80000000, rsp_ovf = 1.
REQ-040 Test: rsp_ready held at 0 for 10 cycles in DONE -> outputs stable and req_ready = 0; then rsp_ready = 1 with a queued request (mode 1, rn = -20, rm = 3) -> accepted on the same edge, next result = 6.
REQ-041 Test: reset_n pulsed low during SETTLE -> rsp_valid never asserts for that request, all outputs return to reset values, and a following request completes normally.
REQ-042 Test: req_rm changed during SETTLE -> div_rm and the result are unaffected.
